// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard controller.
package pipe_ctrl_pkg;

  // ALU control codes that mark a conditional branch in EX
  localparam logic [3:0] ALU_BEQ  = 4'b0110;
  localparam logic [3:0] ALU_BNEQ = 4'b0111;
  localparam logic [3:0] ALU_BGEZ = 4'b1111;

  // EX operand source selects
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  // Branch outcome from the EX ALU flags; any other code is never taken
  function automatic logic branch_resolve(input logic [3:0] ctrl,
                                          input logic       zero,
                                          input logic       neg);
    logic tk;
    tk = 1'b0;
    case (ctrl)
      ALU_BEQ:  tk = zero;
      ALU_BNEQ: tk = ~zero;
      ALU_BGEZ: tk = ~neg;
      default:  tk = 1'b0;
    endcase
    return tk;
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Forwarding mux select for one EX operand. MEM result is newer than WB,
// so it wins; register 0 is hard-wired and never forwarded.
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] ex_src,
  input  logic [4:0] mem_rd,
  input  logic [4:0] wb_rd,
  input  logic       mem_reg_write,
  input  logic       wb_reg_write,
  output logic [1:0] fwd_sel
);

  // Pick the youngest in-flight producer of ex_src
  always_comb begin
    fwd_sel = FWD_REG;
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_src))
      fwd_sel = FWD_MEM;
    else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_src))
      fwd_sel = FWD_WB;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use stalls,
// branch flushes, memory-wait freeze, operand forwarding and debug counters.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_RUN   | normal flow; a load-use hazard here inserts the first bubble
//  ST_STALL | extra load-use bubbles still owed, remain_q counts them down
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_STALL = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_wait,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic [3:0]       ex_alu_ctrl,
  input  logic             ex_alu_zero,
  input  logic             ex_alu_neg,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wb_rd,
  input  logic             mem_reg_write,
  input  logic             wb_reg_write,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             branch_taken,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // First bubble is issued from ST_RUN, so the down-counter reloads with one less
  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL - 1);

  state_t     state_q, state_d;
  logic [2:0] remain_q, remain_d;
  logic       taken, luh;
  logic       stall_inc, flush_inc;

  assign taken = ex_valid & branch_resolve(ex_alu_ctrl, ex_alu_zero, ex_alu_neg);

  assign luh = ex_valid & ex_mem_read & (ex_rd != 5'd0) &
               ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

  // Priority: memory wait, then taken branch, then stall/hazard, then run
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    branch_taken = 1'b0;
    state_d      = state_q;
    remain_d     = remain_q;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    if (mem_wait) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (taken) begin
      // Any owed bubbles belong to the instruction being squashed
      branch_taken = 1'b1;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      flush_inc    = 1'b1;
      state_d      = ST_RUN;
      remain_d     = 3'd0;
    end else if (state_q == ST_STALL) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      stall_inc   = 1'b1;
      if (remain_q == 3'd1) begin
        state_d  = ST_RUN;
        remain_d = 3'd0;
      end else begin
        remain_d = remain_q - 3'd1;
      end
    end else if (luh) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      stall_inc   = 1'b1;
      if (LOAD_STALL > 1) begin
        state_d  = ST_STALL;
        remain_d = STALL_RELOAD;
      end
    end
  end

  // State, bubble down-counter and saturating debug counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      remain_q  <= 3'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      if (stall_inc && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  fwd_unit u_fwd_a (
    .ex_src        (ex_rs),
    .mem_rd        (mem_rd),
    .wb_rd         (wb_rd),
    .mem_reg_write (mem_reg_write),
    .wb_reg_write  (wb_reg_write),
    .fwd_sel       (fwd_a)
  );

  fwd_unit u_fwd_b (
    .ex_src        (ex_rt),
    .mem_rd        (mem_rd),
    .wb_rd         (wb_rd),
    .mem_reg_write (mem_reg_write),
    .wb_reg_write  (wb_reg_write),
    .fwd_sel       (fwd_b)
  );

endmodule
